vx_mem_line_adapter: RTL and testbench
======================================

VX_MEM_LINE_ADAPTER -- requirements
Module: vx_mem_line_adapter

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 4, meaning 32-bit words per line (power of two, >=2); IDXW = log2(LINE_WORDS).
REQ-002 SHALL have parameter TAG_WIDTH_BIT, default 1, meaning width of the upstream request/response tag.
REQ-003 SHALL use one clock and an asynchronous active-low reset: clk_i input 1, rising-edge clock; rst_ni input 1, async active-low reset.
REQ-004 up_req_valid_i  in  1  upstream line request valid; up_req_ready_o  out  1  request accepted.
REQ-005 up_req_rw_i  in  1  1=write, 0=read; up_req_addr_i  in  32  line-aligned byte address.
REQ-006 up_req_byteen_i  in  4*LINE_WORDS  byte enables; up_req_data_i  in  32*LINE_WORDS  write data; up_req_tag_i  in  TAG_WIDTH_BIT  tag.
REQ-007 up_rsp_valid_o  out  1; up_rsp_ready_i  in  1; up_rsp_data_o  out  32*LINE_WORDS  read line; up_rsp_tag_o  out  TAG_WIDTH_BIT.
REQ-008 dn_req_valid_o  out  1; dn_req_ready_i  in  1; dn_req_rw_o  out  1; dn_req_addr_o  out  32; dn_req_byteen_o  out  4; dn_req_data_o  out  32; dn_req_tag_o  out  IDXW  word index.
REQ-009 dn_rsp_valid_i  in  1; dn_rsp_ready_o  out  1; dn_rsp_data_i  in  32; dn_rsp_tag_i  in  IDXW  word index of returned data.

Function
REQ-010 Downstream port SHALL feed the single-word OBI bridge; word k of a line maps to bits [32k+31:32k] of data and [4k+3:4k] of byteen.
REQ-011 FSM states SHALL be IDLE, ISSUE, COLLECT, RESP; unused encodings return to IDLE.
REQ-012 IDLE: up_req_ready_o=1 (independent of valid); on up_req_valid_i, capture rw/addr/byteen/data/tag, clear issue index, response count and line buffer, go to ISSUE next cycle.
REQ-013 ISSUE: current word k drives dn_req_addr_o=addr+4k, dn_req_byteen_o, dn_req_data_o, dn_req_rw_o=rw, dn_req_tag_o=k; all stable while dn_req_valid_o=1 and dn_req_ready_i=0.
REQ-014 Write, word byteen nonzero: dn_req_valid_o=1; on dn_req_ready_i advance k; write word with byteen==0 SHALL be skipped in one cycle with dn_req_valid_o=0.
REQ-015 Read: every word SHALL be issued regardless of byteen, byteen passed through.
REQ-016 Write: after last word (k=LINE_WORDS-1) is handshaken or skipped, go to IDLE; no upstream response is produced for writes.
REQ-017 Read: after last word handshake go to COLLECT if responses outstanding, else straight to RESP.
REQ-018 dn_rsp_ready_o SHALL be 1 in ISSUE and COLLECT during a read, 0 otherwise; each dn_rsp handshake writes dn_rsp_data_i into word dn_rsp_tag_i and increments response count.
REQ-019 Response arriving in same cycle as a request handshake SHALL be accepted; both counters update that cycle.
REQ-020 When response count reaches LINE_WORDS and all words issued, go to RESP next cycle; duplicate index overwrites and still counts.
REQ-021 RESP: up_rsp_valid_o=1, up_rsp_data_o=line buffer, up_rsp_tag_o=captured tag, held until up_rsp_ready_i; then IDLE.
REQ-022 At most one line in flight; up_req_ready_o=0 outside IDLE; addr+4k wraps modulo 2^32.

Reset
REQ-023 rst_ni low SHALL asynchronously force IDLE, clear all captured fields, counters and line buffer; all outputs 0 except up_req_ready_o=1 once in IDLE.
REQ-024 Reset mid-line SHALL abandon the operation with no further downstream or upstream activity; late responses are not accepted (dn_rsp_ready_o=0 in IDLE).

Verification
REQ-025 Read addr=0x100, tag=1, dn_req_ready_i=1, responses in order 0xA0..0xA3 one cycle later -> dn addrs 0x100,0x104,0x108,0x10C; up_rsp_data_o=0xA3A2A1A0 words, tag=1.
REQ-026 Read, responses returned in order 3,1,0,2 -> each word lands at its index; one up_rsp_valid_o pulse after fourth response.
REQ-027 Write byteen=0xF0F0, data words D0..D3 -> only words 1 and 3 issued (addr+4, addr+12, byteen 0xF); no up_rsp_valid_o; back to IDLE.
REQ-028 dn_req_ready_i low 5 cycles on word 2 -> addr/data/tag held constant; up_rsp_ready_i low 3 cycles in RESP -> data/tag held.
REQ-029 Reset asserted in COLLECT after 2 of 4 responses -> all outputs 0, IDLE, up_req_ready_o=1; next read completes normally.
REQ-030 Write byteen=0x0000 -> no dn_req_valid_o, return to IDLE after 4 cycles in ISSUE.

Source files
------------

// File: rtl/vx_mem_line_adapter.sv
// Purpose: splits one upstream cache-line request into LINE_WORDS single-word downstream requests and reassembles read data.
// Latency: 1 cycle capture, then one cycle per issued or skipped word, then collection of outstanding read responses, then 1 response cycle.
// Backpressure: one line in flight (up_req_ready_o only in IDLE); downstream request and upstream response hold stable until their ready.
module vx_mem_line_adapter #(
    parameter  int LINE_WORDS    = 4,
    parameter  int TAG_WIDTH_BIT = 1,
    localparam int IDXW          = $clog2(LINE_WORDS)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    // upstream line request
    input  logic                      up_req_valid_i,
    output logic                      up_req_ready_o,
    input  logic                      up_req_rw_i,
    input  logic [31:0]               up_req_addr_i,
    input  logic [4*LINE_WORDS-1:0]   up_req_byteen_i,
    input  logic [32*LINE_WORDS-1:0]  up_req_data_i,
    input  logic [TAG_WIDTH_BIT-1:0]  up_req_tag_i,
    // upstream line response
    output logic                      up_rsp_valid_o,
    input  logic                      up_rsp_ready_i,
    output logic [32*LINE_WORDS-1:0]  up_rsp_data_o,
    output logic [TAG_WIDTH_BIT-1:0]  up_rsp_tag_o,
    // downstream word request
    output logic                      dn_req_valid_o,
    input  logic                      dn_req_ready_i,
    output logic                      dn_req_rw_o,
    output logic [31:0]               dn_req_addr_o,
    output logic [3:0]                dn_req_byteen_o,
    output logic [31:0]               dn_req_data_o,
    output logic [IDXW-1:0]           dn_req_tag_o,
    // downstream word response
    input  logic                      dn_rsp_valid_i,
    output logic                      dn_rsp_ready_o,
    input  logic [31:0]               dn_rsp_data_i,
    input  logic [IDXW-1:0]           dn_rsp_tag_i
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_COLLECT = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    localparam logic [IDXW:0]   CNT_FULL = (IDXW+1)'(LINE_WORDS);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(LINE_WORDS - 1);

    logic [1:0]                 state_q,  state_d;
    logic                       rw_q,     rw_d;
    logic [31:0]                addr_q,   addr_d;
    logic [4*LINE_WORDS-1:0]    byteen_q, byteen_d;
    logic [32*LINE_WORDS-1:0]   data_q,   data_d;
    logic [TAG_WIDTH_BIT-1:0]   tag_q,    tag_d;
    logic [IDXW-1:0]            idx_q,    idx_d;
    logic [IDXW:0]              cnt_q,    cnt_d;
    logic [32*LINE_WORDS-1:0]   line_q,   line_d;

    logic        in_issue;
    logic [3:0]  cur_be;
    logic [31:0] cur_dat;
    logic        word_skip;
    logic        word_done;
    logic        rsp_fire;

    // Current word selection and handshake qualifiers; all outputs are gated to zero outside their owning state.
    always_comb begin
        in_issue  = (state_q == ST_ISSUE);
        cur_be    = byteen_q[4*int'(idx_q) +: 4];
        cur_dat   = data_q[32*int'(idx_q) +: 32];
        // Write words with no enabled bytes carry nothing, so they retire without a downstream request.
        word_skip = rw_q && (cur_be == 4'h0);
        word_done = in_issue && (word_skip || dn_req_ready_i);

        up_req_ready_o  = (state_q == ST_IDLE);

        dn_req_valid_o  = in_issue && !word_skip;
        dn_req_rw_o     = in_issue ? rw_q : 1'b0;
        dn_req_addr_o   = in_issue ? (addr_q + {{(30-IDXW){1'b0}}, idx_q, 2'b00}) : 32'h0;
        dn_req_byteen_o = in_issue ? cur_be : 4'h0;
        dn_req_data_o   = in_issue ? cur_dat : 32'h0;
        dn_req_tag_o    = in_issue ? idx_q : '0;

        // Read responses may arrive while later words are still being issued.
        dn_rsp_ready_o  = ((state_q == ST_ISSUE) || (state_q == ST_COLLECT)) && !rw_q;
        rsp_fire        = dn_rsp_ready_o && dn_rsp_valid_i;

        up_rsp_valid_o  = (state_q == ST_RESP);
        up_rsp_data_o   = (state_q == ST_RESP) ? line_q : '0;
        up_rsp_tag_o    = (state_q == ST_RESP) ? tag_q : '0;
    end

    // Next-state logic: line capture, word sequencing, response collection.
    always_comb begin
        state_d  = state_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        byteen_d = byteen_q;
        data_d   = data_q;
        tag_d    = tag_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        line_d   = line_q;

        // Duplicate indices overwrite and still count; the count saturates at a full line.
        if (rsp_fire) begin
            line_d[32*int'(dn_rsp_tag_i) +: 32] = dn_rsp_data_i;
            if (cnt_q != CNT_FULL) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (up_req_valid_i) begin
                    rw_d     = up_req_rw_i;
                    addr_d   = up_req_addr_i;
                    byteen_d = up_req_byteen_i;
                    data_d   = up_req_data_i;
                    tag_d    = up_req_tag_i;
                    idx_d    = '0;
                    cnt_d    = '0;
                    line_d   = '0;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (word_done) begin
                    if (idx_q == IDX_LAST) begin
                        if (rw_q) begin
                            state_d = ST_IDLE;
                        end else if (cnt_d == CNT_FULL) begin
                            state_d = ST_RESP;
                        end else begin
                            state_d = ST_COLLECT;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_COLLECT: begin
                if (cnt_d == CNT_FULL) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (up_rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any line in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            rw_q     <= 1'b0;
            addr_q   <= 32'h0;
            byteen_q <= '0;
            data_q   <= '0;
            tag_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            line_q   <= '0;
        end else begin
            state_q  <= state_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            byteen_q <= byteen_d;
            data_q   <= data_d;
            tag_q    <= tag_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            line_q   <= line_d;
        end
    end

endmodule

// File: tb/tb_vx_mem_line_adapter.sv
// Purpose: scoreboard bench for vx_mem_line_adapter with directed line transactions.
// Latency: expectations are queued at issue time and consumed by handshake monitors.
// Backpressure: exercises downstream request stalls and upstream response stalls.
`timescale 1ns/1ps
module tb_vx_mem_line_adapter;

    localparam int LW = 4;
    localparam int TW = 1;
    localparam int IW = 2;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              up_req_valid_i;
    logic              up_req_ready_o;
    logic              up_req_rw_i;
    logic [31:0]       up_req_addr_i;
    logic [4*LW-1:0]   up_req_byteen_i;
    logic [32*LW-1:0]  up_req_data_i;
    logic [TW-1:0]     up_req_tag_i;
    logic              up_rsp_valid_o;
    logic              up_rsp_ready_i;
    logic [32*LW-1:0]  up_rsp_data_o;
    logic [TW-1:0]     up_rsp_tag_o;
    logic              dn_req_valid_o;
    logic              dn_req_ready_i;
    logic              dn_req_rw_o;
    logic [31:0]       dn_req_addr_o;
    logic [3:0]        dn_req_byteen_o;
    logic [31:0]       dn_req_data_o;
    logic [IW-1:0]     dn_req_tag_o;
    logic              dn_rsp_valid_i;
    logic              dn_rsp_ready_o;
    logic [31:0]       dn_rsp_data_i;
    logic [IW-1:0]     dn_rsp_tag_i;

    always #5 clk_i = ~clk_i;

    vx_mem_line_adapter #(.LINE_WORDS(LW), .TAG_WIDTH_BIT(TW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .up_req_valid_i(up_req_valid_i), .up_req_ready_o(up_req_ready_o),
        .up_req_rw_i(up_req_rw_i), .up_req_addr_i(up_req_addr_i),
        .up_req_byteen_i(up_req_byteen_i), .up_req_data_i(up_req_data_i),
        .up_req_tag_i(up_req_tag_i),
        .up_rsp_valid_o(up_rsp_valid_o), .up_rsp_ready_i(up_rsp_ready_i),
        .up_rsp_data_o(up_rsp_data_o), .up_rsp_tag_o(up_rsp_tag_o),
        .dn_req_valid_o(dn_req_valid_o), .dn_req_ready_i(dn_req_ready_i),
        .dn_req_rw_o(dn_req_rw_o), .dn_req_addr_o(dn_req_addr_o),
        .dn_req_byteen_o(dn_req_byteen_o), .dn_req_data_o(dn_req_data_o),
        .dn_req_tag_o(dn_req_tag_o),
        .dn_rsp_valid_i(dn_rsp_valid_i), .dn_rsp_ready_o(dn_rsp_ready_o),
        .dn_rsp_data_i(dn_rsp_data_i), .dn_rsp_tag_i(dn_rsp_tag_i)
    );

    typedef struct packed {
        logic          rw;
        logic [31:0]   addr;
        logic [3:0]    be;
        logic [31:0]   dat;
        logic [IW-1:0] tag;
    } dn_exp_t;

    typedef struct packed {
        logic [32*LW-1:0] dat;
        logic [TW-1:0]    tag;
    } up_exp_t;

    typedef struct packed {
        logic [IW-1:0] tag;
        logic [31:0]   dat;
    } rsp_t;

    dn_exp_t exp_dn[$];
    up_exp_t exp_up[$];
    rsp_t    rsp_q[$];
    dn_exp_t de;
    up_exp_t ue;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_dn_hs = 0;
    int   n_up_hs = 0;
    bit   auto_rsp = 1'b0;
    logic [31:0] rsp_base = 32'h0;
    bit   rsp_hs;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_dn(input logic rw, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] dat, input logic [IW-1:0] tag);
        exp_dn.push_back('{rw: rw, addr: addr, be: be, dat: dat, tag: tag});
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Downstream request and upstream response monitors, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (rst_ni && dn_req_valid_o && dn_req_ready_i) begin
            n_dn_hs++;
            if (exp_dn.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL dn_req_unexpected: addr 0x%0h tag %0d issued, no request expected",
                         dn_req_addr_o, dn_req_tag_o);
            end else begin
                de = exp_dn.pop_front();
                chk("dn_req_rw",     dn_req_rw_o,     de.rw);
                chk("dn_req_addr",   dn_req_addr_o,   de.addr);
                chk("dn_req_byteen", dn_req_byteen_o, de.be);
                chk("dn_req_data",   dn_req_data_o,   de.dat);
                chk("dn_req_tag",    dn_req_tag_o,    de.tag);
            end
            if (auto_rsp && !dn_req_rw_o) begin
                rsp_q.push_back('{tag: dn_req_tag_o, dat: rsp_base + 32'(dn_req_tag_o)});
            end
        end
        if (rst_ni && up_rsp_valid_o && up_rsp_ready_i) begin
            n_up_hs++;
            if (exp_up.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL up_rsp_unexpected: data 0x%0h tag %0d, no response expected",
                         up_rsp_data_o, up_rsp_tag_o);
            end else begin
                ue = exp_up.pop_front();
                chk("up_rsp_data", up_rsp_data_o, ue.dat);
                chk("up_rsp_tag",  up_rsp_tag_o,  ue.tag);
            end
        end
    end

    // Downstream responder: presents queued word responses in order, one per handshake.
    initial begin
        dn_rsp_valid_i = 1'b0;
        dn_rsp_tag_i   = '0;
        dn_rsp_data_i  = '0;
        forever begin
            @(negedge clk_i);
            rsp_hs = dn_rsp_valid_i && dn_rsp_ready_o;
            @(posedge clk_i);
            #1;
            if (rsp_hs && rsp_q.size() > 0) void'(rsp_q.pop_front());
            if (rsp_q.size() > 0) begin
                dn_rsp_valid_i = 1'b1;
                dn_rsp_tag_i   = rsp_q[0].tag;
                dn_rsp_data_i  = rsp_q[0].dat;
            end else begin
                dn_rsp_valid_i = 1'b0;
            end
        end
    end

    task automatic send_req(input logic rw, input logic [31:0] addr, input logic [15:0] be,
                            input logic [127:0] dat, input logic [TW-1:0] tag);
        bit acc;
        acc = 1'b0;
        up_req_valid_i  = 1'b1;
        up_req_rw_i     = rw;
        up_req_addr_i   = addr;
        up_req_byteen_i = be;
        up_req_data_i   = dat;
        up_req_tag_i    = tag;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk_i);
            acc = up_req_ready_o;
            step();
        end
        up_req_valid_i = 1'b0;
        if (!acc) begin
            n_chk++;
            n_fail++;
            $display("FAIL up_req_accept: request at 0x%0h not accepted within 50 cycles", addr);
        end
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk_i);
            ok = up_req_ready_o && (exp_dn.size() == 0) && (exp_up.size() == 0);
        end
        chk(name, ok, 1'b1);
        step();
    endtask

    task automatic wait_dn_hs(input string name, input int target);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            step();
            ok = (n_dn_hs >= target);
        end
        chk(name, ok, 1'b1);
    endtask

    int base;
    int cyc;
    bit found;

    initial begin
        rst_ni          = 1'b0;
        up_req_valid_i  = 1'b0;
        up_req_rw_i     = 1'b0;
        up_req_addr_i   = '0;
        up_req_byteen_i = '0;
        up_req_data_i   = '0;
        up_req_tag_i    = '0;
        up_rsp_ready_i  = 1'b1;
        dn_req_ready_i  = 1'b1;
        repeat (3) @(posedge clk_i);

        // Reset state
        @(negedge clk_i);
        chk("rst_up_req_ready", up_req_ready_o, 1'b1);
        chk("rst_dn_req_valid", dn_req_valid_o, 1'b0);
        chk("rst_dn_rsp_ready", dn_rsp_ready_o, 1'b0);
        chk("rst_up_rsp_valid", up_rsp_valid_o, 1'b0);
        chk("rst_dn_req_addr",  dn_req_addr_o,  32'h0);
        chk("rst_up_rsp_data",  up_rsp_data_o,  128'h0);
        step();
        rst_ni = 1'b1;
        step();

        // In-order read at 0x100, responses one cycle after each request
        auto_rsp = 1'b1;
        rsp_base = 32'hA0;
        push_dn(1'b0, 32'h100, 4'hF, 32'hD0, 2'd0);
        push_dn(1'b0, 32'h104, 4'hF, 32'hD1, 2'd1);
        push_dn(1'b0, 32'h108, 4'hF, 32'hD2, 2'd2);
        push_dn(1'b0, 32'h10C, 4'hF, 32'hD3, 2'd3);
        exp_up.push_back('{dat: {32'hA3, 32'hA2, 32'hA1, 32'hA0}, tag: 1'b1});
        send_req(1'b0, 32'h100, 16'hFFFF, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 1'b1);
        wait_done("read_inorder_done");

        // Out-of-order responses 3,1,0,2; read byteen passes through even where zero
        auto_rsp = 1'b0;
        base = n_dn_hs;
        push_dn(1'b0, 32'h200, 4'h0, 32'h50, 2'd0);
        push_dn(1'b0, 32'h204, 4'h3, 32'h51, 2'd1);
        push_dn(1'b0, 32'h208, 4'hF, 32'h52, 2'd2);
        push_dn(1'b0, 32'h20C, 4'h0, 32'h53, 2'd3);
        exp_up.push_back('{dat: {32'hB3, 32'hB2, 32'hB1, 32'hB0}, tag: 1'b0});
        send_req(1'b0, 32'h200, 16'h0F30, {32'h53, 32'h52, 32'h51, 32'h50}, 1'b0);
        wait_dn_hs("oor_issue_done", base + 4);
        base = n_up_hs;
        rsp_q.push_back('{tag: 2'd3, dat: 32'hB3});
        rsp_q.push_back('{tag: 2'd1, dat: 32'hB1});
        rsp_q.push_back('{tag: 2'd0, dat: 32'hB0});
        rsp_q.push_back('{tag: 2'd2, dat: 32'hB2});
        wait_done("read_oor_done");
        chk("oor_rsp_pulses", n_up_hs - base, 1);

        // Write with byteen 0xF0F0: only words 1 and 3 go downstream
        base = n_up_hs;
        push_dn(1'b1, 32'h304, 4'hF, 32'hC1, 2'd1);
        push_dn(1'b1, 32'h30C, 4'hF, 32'hC3, 2'd3);
        send_req(1'b1, 32'h300, 16'hF0F0, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 1'b1);
        wait_done("write_sparse_done");
        chk("write_no_up_rsp", n_up_hs - base, 0);

        // Write with all byteen clear: four skip cycles in ISSUE, no downstream traffic
        base = n_dn_hs;
        send_req(1'b1, 32'h400, 16'h0000, {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 1'b0);
        cyc = 0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk_i);
            if (up_req_ready_o) found = 1'b1;
            else cyc++;
        end
        chk("be0_issue_cycles", cyc, 4);
        chk("be0_no_dn_req", n_dn_hs - base, 0);
        step();

        // Read across the 2^32 wrap with a 5-cycle stall on word 2 and a 3-cycle response stall
        auto_rsp = 1'b1;
        rsp_base = 32'hE0;
        up_rsp_ready_i = 1'b0;
        push_dn(1'b0, 32'hFFFF_FFF8, 4'hF, 32'hF0, 2'd0);
        push_dn(1'b0, 32'hFFFF_FFFC, 4'hF, 32'hF1, 2'd1);
        push_dn(1'b0, 32'h0000_0000, 4'hF, 32'hF2, 2'd2);
        push_dn(1'b0, 32'h0000_0004, 4'hF, 32'hF3, 2'd3);
        exp_up.push_back('{dat: {32'hE3, 32'hE2, 32'hE1, 32'hE0}, tag: 1'b1});
        send_req(1'b0, 32'hFFFF_FFF8, 16'hFFFF, {32'hF3, 32'hF2, 32'hF1, 32'hF0}, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk_i);
            found = dn_req_valid_o && (dn_req_tag_o == 2'd1);
        end
        chk("stall_reach_word1", found, 1'b1);
        step();
        dn_req_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("stall_dn_valid", dn_req_valid_o, 1'b1);
            chk("stall_dn_addr",  dn_req_addr_o,  32'h0);
            chk("stall_dn_data",  dn_req_data_o,  32'hF2);
            chk("stall_dn_tag",   dn_req_tag_o,   2'd2);
        end
        step();
        dn_req_ready_i = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk_i);
            found = up_rsp_valid_o;
        end
        chk("resp_stall_reach", found, 1'b1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk_i);
            chk("resp_stall_valid", up_rsp_valid_o, 1'b1);
            chk("resp_stall_data",  up_rsp_data_o,  {32'hE3, 32'hE2, 32'hE1, 32'hE0});
            chk("resp_stall_tag",   up_rsp_tag_o,   1'b1);
        end
        step();
        up_rsp_ready_i = 1'b1;
        wait_done("read_stall_done");

        // Reset in COLLECT after two of four responses; the line is abandoned
        auto_rsp = 1'b0;
        base = n_dn_hs;
        push_dn(1'b0, 32'h500, 4'hF, 32'h60, 2'd0);
        push_dn(1'b0, 32'h504, 4'hF, 32'h61, 2'd1);
        push_dn(1'b0, 32'h508, 4'hF, 32'h62, 2'd2);
        push_dn(1'b0, 32'h50C, 4'hF, 32'h63, 2'd3);
        send_req(1'b0, 32'h500, 16'hFFFF, {32'h63, 32'h62, 32'h61, 32'h60}, 1'b0);
        wait_dn_hs("rst_issue_done", base + 4);
        rsp_q.push_back('{tag: 2'd0, dat: 32'h90});
        rsp_q.push_back('{tag: 2'd1, dat: 32'h91});
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = (rsp_q.size() == 0);
        end
        chk("rst_two_rsp_taken", found, 1'b1);
        chk("rst_pre_collect", dn_rsp_ready_o, 1'b1);
        rst_ni = 1'b0;
        #1;
        chk("midrst_up_req_ready", up_req_ready_o, 1'b1);
        chk("midrst_dn_req_valid", dn_req_valid_o, 1'b0);
        chk("midrst_dn_rsp_ready", dn_rsp_ready_o, 1'b0);
        chk("midrst_up_rsp_valid", up_rsp_valid_o, 1'b0);
        chk("midrst_up_rsp_data",  up_rsp_data_o,  128'h0);
        chk("midrst_dn_req_addr",  dn_req_addr_o,  32'h0);
        rsp_q.delete();
        step();
        step();
        rst_ni = 1'b1;
        step();

        // Next read after reset completes normally
        auto_rsp = 1'b1;
        rsp_base = 32'h70;
        push_dn(1'b0, 32'h600, 4'hF, 32'h80, 2'd0);
        push_dn(1'b0, 32'h604, 4'hF, 32'h81, 2'd1);
        push_dn(1'b0, 32'h608, 4'hF, 32'h82, 2'd2);
        push_dn(1'b0, 32'h60C, 4'hF, 32'h83, 2'd3);
        exp_up.push_back('{dat: {32'h73, 32'h72, 32'h71, 32'h70}, tag: 1'b0});
        send_req(1'b0, 32'h600, 16'hFFFF, {32'h83, 32'h82, 32'h81, 32'h80}, 1'b0);
        wait_done("read_after_rst_done");

        repeat (5) step();
        chk("final_dn_queue_empty", exp_dn.size(), 0);
        chk("final_up_queue_empty", exp_up.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
